// File: rtl/lfsr_crc_core_if.sv
// rtl/lfsr_crc_core_if.sv - data/CRC bundle between a word source and lfsr_crc_core
//
// Purpose : groups the per-word input qualifier, the input word and the
//           continuously presented CRC into one connection.
// Signals : data_in       - input word, DATA_WIDTH bits
//           data_in_valid - qualifies data_in in the current cycle
//           crc_out       - current CRC, OUTPUT_WIDTH bits
// Modports: master - word source (drives data, observes CRC)
//           slave  - CRC core (consumes data, drives CRC)

interface lfsr_crc_core_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int OUTPUT_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    data_in_valid;
    logic [OUTPUT_WIDTH-1:0] crc_out;

    modport master (
        output data_in,
        output data_in_valid,
        input  crc_out
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output crc_out
    );
endinterface

// File: rtl/lfsr_crc_core.sv
// rtl/lfsr_crc_core.sv - single-cycle multi-bit LFSR/CRC generator
//
// Purpose : advances an LFSR_WIDTH-bit LFSR state by DATA_WIDTH shift steps
//           per valid input word and presents the (optionally reflected and
//           inverted) state as a CRC. Galois or Fibonacci feedback; next-state
//           logic built either as an explicit bit loop or as per-bit constant
//           XOR masks over {state, data}.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset, loads LFSR_INIT
//           bus - slave side of lfsr_crc_core_if (data_in, data_in_valid,
//                 crc_out); crc_out is driven only from the state register

module lfsr_crc_core #(
    parameter int                     LFSR_WIDTH   = 32,
    parameter logic [LFSR_WIDTH-1:0]  LFSR_POLY    = LFSR_WIDTH'(32'h04c11db7),
    parameter logic [LFSR_WIDTH-1:0]  LFSR_INIT    = '1,
    parameter string                  LFSR_CONFIG  = "GALOIS",
    parameter bit                     REVERSE      = 1'b1,
    parameter bit                     INVERT       = 1'b1,
    parameter int                     DATA_WIDTH   = 64,
    parameter int                     OUTPUT_WIDTH = LFSR_WIDTH,
    parameter string                  STYLE        = "AUTO"
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_crc_core_if.slave     bus
);

    localparam bit IS_FIB   = (LFSR_CONFIG == "FIBONACCI");
    localparam bit USE_LOOP = (STYLE == "LOOP");
    // Mask vectors index the concatenation {state, data}: state bits occupy
    // [TW-1:DATA_WIDTH], data bits occupy [DATA_WIDTH-1:0].
    localparam int TW = LFSR_WIDTH + DATA_WIDTH;

    typedef logic [LFSR_WIDTH-1:0][TW-1:0] mask_arr_t;

    // Index of the data bit consumed at shift step k.
    function automatic int data_index(input int k);
        return REVERSE ? k : (DATA_WIDTH - 1 - k);
    endfunction

    // Runs the LFSR symbolically: each state bit is tracked as the set of
    // {state, data} inputs it is the XOR of. Because every step is linear,
    // the final sets are exactly the per-bit reduction masks.
    function automatic mask_arr_t build_masks();
        mask_arr_t        m;
        logic [TW-1:0]    fb;
        logic [TW-1:0]    dm;
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            m[i] = '0;
            m[i][DATA_WIDTH + i] = 1'b1;
        end
        for (int k = 0; k < DATA_WIDTH; k++) begin
            dm = '0;
            dm[data_index(k)] = 1'b1;
            fb = dm ^ m[LFSR_WIDTH-1];
            if (IS_FIB) begin
                for (int i = 1; i < LFSR_WIDTH; i++) begin
                    if (LFSR_POLY[i]) begin
                        fb = fb ^ m[i-1];
                    end
                end
                for (int i = LFSR_WIDTH - 1; i > 0; i--) begin
                    m[i] = m[i-1];
                end
                m[0] = fb;
            end else begin
                for (int i = LFSR_WIDTH - 1; i > 0; i--) begin
                    m[i] = m[i-1] ^ (LFSR_POLY[i] ? fb : '0);
                end
                m[0] = LFSR_POLY[0] ? fb : '0;
            end
        end
        return m;
    endfunction

    logic [LFSR_WIDTH-1:0] state_q;
    logic [LFSR_WIDTH-1:0] state_d;
    logic [LFSR_WIDTH-1:0] next_state;

    generate
        if (USE_LOOP) begin : g_loop
            always_comb begin
                logic [LFSR_WIDTH-1:0] s;
                logic                  fb;
                s = state_q;
                for (int k = 0; k < DATA_WIDTH; k++) begin
                    fb = s[LFSR_WIDTH-1] ^ bus.data_in[data_index(k)];
                    if (IS_FIB) begin
                        for (int i = 1; i < LFSR_WIDTH; i++) begin
                            if (LFSR_POLY[i]) begin
                                fb = fb ^ s[i-1];
                            end
                        end
                        s = {s[LFSR_WIDTH-2:0], fb};
                    end else begin
                        s = {s[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
                    end
                end
                next_state = s;
            end
        end else begin : g_reduction
            localparam mask_arr_t MASKS = build_masks();
            logic [TW-1:0] taps;
            assign taps = {state_q, bus.data_in};
            for (genvar i = 0; i < LFSR_WIDTH; i++) begin : g_bit
                assign next_state[i] = ^(taps & MASKS[i]);
            end
        end
    endgenerate

    assign state_d = bus.data_in_valid ? next_state : state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LFSR_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Output post-processing: reflection then complement, low bits kept.
    logic [LFSR_WIDTH-1:0] crc_full;

    always_comb begin
        crc_full = state_q;
        if (REVERSE) begin
            for (int i = 0; i < LFSR_WIDTH; i++) begin
                crc_full[i] = state_q[LFSR_WIDTH-1-i];
            end
        end
        if (INVERT) begin
            crc_full = ~crc_full;
        end
    end

    assign bus.crc_out = crc_full[OUTPUT_WIDTH-1:0];

endmodule

// File: tb/tb_lfsr_crc_core.sv
// tb/tb_lfsr_crc_core.sv - directed self-checking bench for lfsr_crc_core

module tb_lfsr_crc_core;

    localparam logic [31:0] POLY  = 32'h04c11db7;
    localparam logic [63:0] W1234 = 64'h3837363534333231;
    localparam logic [31:0] C1234 = 32'h9AE0DAAF;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference registers: software reflected CRC-32, MSB-first Galois state,
    // MSB-first Fibonacci state.
    logic [31:0] r_m;
    logic [31:0] g_m;
    logic [31:0] f_m;

    lfsr_crc_core_if #(.DATA_WIDTH(64), .OUTPUT_WIDTH(32)) if_a  ();
    lfsr_crc_core_if #(.DATA_WIDTH(64), .OUTPUT_WIDTH(32)) if_l  ();
    lfsr_crc_core_if #(.DATA_WIDTH(64), .OUTPUT_WIDTH(32)) if_gl ();
    lfsr_crc_core_if #(.DATA_WIDTH(64), .OUTPUT_WIDTH(32)) if_gr ();
    lfsr_crc_core_if #(.DATA_WIDTH(64), .OUTPUT_WIDTH(32)) if_fl ();
    lfsr_crc_core_if #(.DATA_WIDTH(64), .OUTPUT_WIDTH(32)) if_fr ();

    lfsr_crc_core u_auto (.clk(clk), .rst(rst), .bus(if_a));

    lfsr_crc_core #(.STYLE("LOOP")) u_loop (.clk(clk), .rst(rst), .bus(if_l));

    lfsr_crc_core #(.REVERSE(1'b0), .INVERT(1'b0), .STYLE("LOOP"))
        u_gl (.clk(clk), .rst(rst), .bus(if_gl));

    lfsr_crc_core #(.REVERSE(1'b0), .INVERT(1'b0), .STYLE("REDUCTION"))
        u_gr (.clk(clk), .rst(rst), .bus(if_gr));

    lfsr_crc_core #(.LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b0), .INVERT(1'b0), .STYLE("LOOP"))
        u_fl (.clk(clk), .rst(rst), .bus(if_fl));

    lfsr_crc_core #(.LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b0), .INVERT(1'b0), .STYLE("REDUCTION"))
        u_fr (.clk(clk), .rst(rst), .bus(if_fr));

    function automatic logic [31:0] sw_crc32(input logic [31:0] r, input logic [63:0] d);
        logic [31:0] c;
        c = r;
        for (int b = 0; b < 8; b++) begin
            c = c ^ {24'h0, d[8*b +: 8]};
            for (int j = 0; j < 8; j++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] galois_msb(input logic [31:0] s, input logic [63:0] d);
        logic [31:0] g;
        logic        fb;
        g = s;
        for (int k = 63; k >= 0; k--) begin
            fb = g[31] ^ d[k];
            g  = (g << 1) ^ (fb ? POLY : 32'h0);
        end
        return g;
    endfunction

    function automatic logic [31:0] fib_msb(input logic [31:0] s, input logic [63:0] d);
        logic [31:0] f;
        logic        fb;
        f = s;
        for (int k = 63; k >= 0; k--) begin
            fb = d[k] ^ f[31] ^ (^(f[30:0] & POLY[31:1]));
            f  = {f[30:0], fb};
        end
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d);
        if_a.data_in_valid  = v;  if_a.data_in  = d;
        if_l.data_in_valid  = v;  if_l.data_in  = d;
        if_gl.data_in_valid = v;  if_gl.data_in = d;
        if_gr.data_in_valid = v;  if_gr.data_in = d;
        if_fl.data_in_valid = v;  if_fl.data_in = d;
        if_fr.data_in_valid = v;  if_fr.data_in = d;
    endtask

    task automatic reset_models();
        r_m = 32'hFFFFFFFF;
        g_m = 32'hFFFFFFFF;
        f_m = 32'hFFFFFFFF;
    endtask

    task automatic update_models(input logic [63:0] d);
        r_m = sw_crc32(r_m, d);
        g_m = galois_msb(g_m, d);
        f_m = fib_msb(f_m, d);
    endtask

    task automatic check_all(input string tag);
        check({tag, "/auto"},   if_a.crc_out,  ~r_m);
        check({tag, "/loop"},   if_l.crc_out,  ~r_m);
        check({tag, "/gal_lp"}, if_gl.crc_out, g_m);
        check({tag, "/gal_rd"}, if_gr.crc_out, g_m);
        check({tag, "/fib_lp"}, if_fl.crc_out, f_m);
        check({tag, "/fib_rd"}, if_fr.crc_out, f_m);
    endtask

    // Called at a falling edge; drives, waits for the rising edge, samples
    // 1 time unit later and returns at the next falling edge.
    task automatic step(input string tag, input logic v, input logic [63:0] d);
        drive(v, d);
        @(posedge clk);
        #1;
        if (v) begin
            update_models(d);
        end
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 64'h0);
        reset_models();
        #12;
        check("reset_auto", if_a.crc_out, 32'h00000000);
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step("idle", 1'b0, {$urandom, $urandom});
        end
        check("idle_zero", if_a.crc_out, 32'h00000000);

        step("single", 1'b1, W1234);
        check("single_const", if_a.crc_out, C1234);

        for (int i = 0; i < 10; i++) begin
            step("hold", 1'b0, {$urandom, $urandom});
        end
        check("hold_const", if_a.crc_out, C1234);

        rst = 1'b1;
        #1;
        reset_models();
        check_all("rst_pulse");
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step("frame", 1'b1, {$urandom, $urandom});
        end

        // Reset lands between edges while a frame is in flight.
        drive(1'b0, {$urandom, $urandom});
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", if_a.crc_out, 32'h00000000);
        reset_models();
        check_all("async");
        #1;
        rst = 1'b0;
        @(negedge clk);

        step("resend", 1'b1, W1234);
        check("resend_const", if_a.crc_out, C1234);

        rst = 1'b1;
        #1;
        reset_models();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step("gapped", 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
